// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer sequencing controller: in-order allocation, completion tracking,
// in-order commit and mispredict tail rewind. Define ROB_STATS_EN for stall/flush counters.
module rob_alloc_ctrl #(
    parameter int unsigned ROB_SIZE = 8,
    parameter int unsigned IDX_W    = $clog2(ROB_SIZE)
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_alloc_valid,
    output logic             out_alloc_ready,
    output logic [IDX_W-1:0] out_alloc_idx,
    input  logic             in_wb_valid,
    input  logic [IDX_W-1:0] in_wb_idx,
    output logic             out_commit_valid,
    output logic [IDX_W-1:0] out_commit_idx,
    input  logic             in_commit_ready,
    input  logic             in_flush_valid,
    input  logic [IDX_W-1:0] in_flush_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_full,
    output logic             out_empty
`ifdef ROB_STATS_EN
    ,
    output logic [15:0]      out_stall_full_cnt,
    output logic [15:0]      out_flush_cnt
`endif
);

    localparam logic       ST_RUN     = 1'b0;
    localparam logic       ST_RECOVER = 1'b1;
    localparam logic [IDX_W:0] SIZE_C = (IDX_W+1)'(ROB_SIZE);

    logic [IDX_W:0]        head_q, head_d;
    logic [IDX_W:0]        tail_q, tail_d;
    logic [ROB_SIZE-1:0]   done_q, done_d;
    logic                  state_q, state_d;

    logic [IDX_W:0]        count;
    logic                  full, empty;
    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic [IDX_W-1:0]      wb_off, flush_off;
    logic                  wb_accept, flush_accept;
    logic                  alloc_fire, commit_fire;

    // Distance of an index from the head, modulo ROB_SIZE.
    function automatic logic [IDX_W-1:0] rel_off(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] base);
        return idx - base;
    endfunction

    assign count    = tail_q - head_q;
    assign full     = (count == SIZE_C);
    assign empty    = (count == '0);
    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign wb_off       = rel_off(in_wb_idx, head_idx);
    assign flush_off    = rel_off(in_flush_idx, head_idx);
    assign wb_accept    = in_wb_valid && ({1'b0, wb_off} < count);
    assign flush_accept = in_flush_valid && ({1'b0, flush_off} < count);

    assign out_alloc_ready  = (state_q == ST_RUN) && !full && !flush_accept;
    assign out_alloc_idx    = tail_idx;
    assign out_commit_valid = !empty && done_q[head_idx];
    assign out_commit_idx   = head_idx;
    assign out_count        = count;
    assign out_full         = full;
    assign out_empty        = empty;

    assign alloc_fire  = in_alloc_valid && out_alloc_ready;
    assign commit_fire = out_commit_valid && in_commit_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        done_d  = done_q;
        state_d = flush_accept ? ST_RECOVER : ST_RUN;

        if (wb_accept) begin
            done_d[in_wb_idx] = 1'b1;
        end
        if (commit_fire) begin
            done_d[head_idx] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (alloc_fire) begin
            done_d[tail_idx] = 1'b0;
            tail_d           = tail_q + 1'b1;
        end
        // Squash clears run after writeback so a same-cycle wb to a younger entry is dropped.
        if (flush_accept) begin
            tail_d = head_q + {1'b0, flush_off} + 1'b1;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                if ((rel_off(IDX_W'(i), head_idx) > flush_off) &&
                    ({1'b0, rel_off(IDX_W'(i), head_idx)} < count)) begin
                    done_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            done_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

`ifdef ROB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_alloc_valid && full && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_accept && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_stall_full_cnt = stall_cnt_q;
    assign out_flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Sequencing controller for the reorder buffer storage array. Hands out ROB indices to dispatch in program order and tracks FU completion per entry. Drives in-order commit to the regfile and rewinds the tail on branch mispredict. Sits between dispatch, FU writeback, the ROB array and the regfile commit port.

Parameters:
ROB_SIZE, 8, number of ROB entries; power of 2, minimum 4
IDX_W, $clog2(ROB_SIZE), ROB index width

Ports:
in_clk  input  1  clock; all state updates on posedge
in_rst_n  input  1  asynchronous active-low reset
in_alloc_valid  input  1  dispatch requests one new entry
out_alloc_ready  output  1  entry available and controller in RUN
out_alloc_idx  output  IDX_W  index granted when valid&&ready
in_wb_valid  input  1  FU writeback of a result
in_wb_idx  input  IDX_W  ROB index being completed
out_commit_valid  output  1  head entry complete, commit offered
out_commit_idx  output  IDX_W  head index
in_commit_ready  input  1  regfile accepts commit this cycle
in_flush_valid  input  1  mispredict flush request
in_flush_idx  input  IDX_W  ROB index of mispredicted branch (kept); younger entries squashed
out_count  output  IDX_W+1  occupied entries
out_full  output  1  out_count == ROB_SIZE
out_empty  output  1  out_count == 0

Behaviour:
- State: head/tail pointers IDX_W+1 bits wide (extra wrap bit); done[ROB_SIZE] bit vector; FSM {RUN, RECOVER}.
- Reset (async, in_rst_n=0): head=tail=0, done=0, FSM=RUN. Outputs: out_alloc_ready=1, out_alloc_idx=0, out_commit_valid=0, out_commit_idx=0, out_count=0, out_full=0, out_empty=1. Reset mid-operation discards all entries immediately.
- count = tail - head (IDX_W+1 bit modular); full when count==ROB_SIZE; empty when count==0.
- Alloc: out_alloc_ready = (FSM==RUN) && !full. out_alloc_idx = tail[IDX_W-1:0]. On valid&&ready: done[tail] <= 0, tail <= tail+1. Index is usable by dispatch in the same cycle.
- Writeback: in_wb_valid sets done[in_wb_idx] at next edge. It is ignored if the index is not occupied, i.e. the offset (idx - head) mod ROB_SIZE >= count. Writeback to an already-done entry is harmless.
- Commit: out_commit_valid = !empty && done[head]; out_commit_idx = head[IDX_W-1:0]. On valid&&ready: done[head] <= 0, head <= head+1. One commit per cycle maximum. A writeback landing on the head is visible for commit one cycle later, not the same cycle.
- Full and commit in the same cycle: out_alloc_ready stays 0 that cycle. Ready is derived from the current count; the freed slot is grantable next cycle.
- Empty and alloc in the same cycle: alloc proceeds. No commit is offered that cycle.
- Flush: accepted only if in_flush_idx is occupied; otherwise ignored.
  - On accept: tail <= flush position + 1 (wrap bit computed relative to head). Squashed entries get done cleared. FSM -> RECOVER.
  - Flush beats a same-cycle alloc: the alloc is not granted because ready is forced 0 in that cycle.
  - Writeback to a squashed index in the flush cycle is dropped.
  - Commit of head in the flush cycle proceeds normally, since the head is never younger than the branch.
- RECOVER: lasts exactly 1 cycle. out_alloc_ready=0; commit continues. Then -> RUN. A flush arriving in RECOVER is processed identically and stays in RECOVER one more cycle.
- Wrap-around: all index arithmetic is mod ROB_SIZE; the pointer wrap bit distinguishes full from empty.

Optional Feature:
ROB_STATS_EN: when defined, adds outputs out_stall_full_cnt (16b) and out_flush_cnt (16b), both saturating, cleared on reset.
- out_stall_full_cnt increments each cycle with in_alloc_valid && full.
- out_flush_cnt increments on each accepted flush.
When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, alloc 3 cycles -> idx 0,1,2 granted; out_count=3, out_empty=0, no commit offered.
- Writeback idx 1 then idx 0 -> commit_valid rises the cycle after idx 0's wb; commits 0 then 1 in order with commit_ready=1; out_count=1.
- Fill 8 entries -> out_full=1, alloc_ready=0. Complete and commit idx 0 with alloc_valid held -> grant of idx 0 (wrapped) the following cycle; count returns to 8.
- Entries 0-5 allocated, flush idx 2 -> tail=3, count=3, done[3..5] cleared, alloc_ready=0 for 1 cycle, next alloc gets idx 3.
- Flush idx 6 while only 0-3 occupied -> ignored; count unchanged; FSM stays RUN.
- Assert in_rst_n=0 mid-stream with count=5 -> all outputs at reset values immediately, before the next clock edge.
